// File: rtl/cdb_publisher_pkg.sv
// ============================================================================
// Module : cdb_publisher_pkg
// Brief  : Shared CDB widths and round-robin helper used by CDB producers/consumers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_publisher_pkg;

  localparam int CDB_N_REQ  = 4;
  localparam int CDB_W_TAG  = 6;
  localparam int CDB_W_DATA = 32;

  // Successor of idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; pointer moves past each winner.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import cdb_publisher_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = PW'(rr_next(int'(win), N));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_publisher.sv
// ============================================================================
// Module : cdb_publisher
// Brief  : CDB transmitter: per-unit holding slots, round-robin pick, registered bus.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_publisher
  import cdb_publisher_pkg::*;
#(
  parameter int N_REQ  = CDB_N_REQ,
  parameter int W_TAG  = CDB_W_TAG,
  parameter int W_DATA = CDB_W_DATA
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*W_TAG-1:0]    req_tag,
  input  logic [N_REQ*W_DATA-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      cdb_valid,
  output logic [W_TAG-1:0]          cdb_tag,
  output logic [W_DATA-1:0]         cdb_data,
  output logic [N_REQ-1:0]          cdb_grant_onehot
);

  logic [N_REQ-1:0]  slot_valid_q;
  logic [W_TAG-1:0]  slot_tag_q  [N_REQ];
  logic [W_DATA-1:0] slot_data_q [N_REQ];
  logic [W_TAG-1:0]  req_tag_w   [N_REQ];
  logic [W_DATA-1:0] req_data_w  [N_REQ];

  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  transfer;
  logic [W_TAG-1:0]  win_tag_d;
  logic [W_DATA-1:0] win_data_d;

  logic              cdb_valid_q;
  logic [W_TAG-1:0]  cdb_tag_q;
  logic [W_DATA-1:0] cdb_data_q;
  logic [N_REQ-1:0]  cdb_grant_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_tag_w[i]  = req_tag[i*W_TAG +: W_TAG];
    assign req_data_w[i] = req_data[i*W_DATA +: W_DATA];
  end

  // Arbitration looks only at held slots, so new requests never bypass the slot stage.
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (slot_valid_q),
    .grant (grant)
  );

  assign req_ready = reset ? '0 : (~slot_valid_q | grant);
  assign transfer  = req_valid & req_ready;

  always_comb begin
    win_tag_d  = '0;
    win_data_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_tag_d  |= slot_tag_q[i];
        win_data_d |= slot_data_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        slot_tag_q[i]  <= '0;
        slot_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (transfer[i]) begin
          slot_valid_q[i] <= 1'b1;
          slot_tag_q[i]   <= req_tag_w[i];
          slot_data_q[i]  <= req_data_w[i];
        end else if (grant[i]) begin
          slot_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_grant_q <= '0;
    end else begin
      cdb_valid_q <= |grant;
      cdb_tag_q   <= win_tag_d;
      cdb_data_q  <= win_data_d;
      cdb_grant_q <= grant;
    end
  end

  assign cdb_valid        = cdb_valid_q;
  assign cdb_tag          = cdb_tag_q;
  assign cdb_data         = cdb_data_q;
  assign cdb_grant_onehot = cdb_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_publisher.sv
// ============================================================================
// Module : tb_cdb_publisher
// Brief  : Randomized scoreboard bench for cdb_publisher against a transaction model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_publisher;

  localparam int N  = 4;
  localparam int WT = 6;
  localparam int WD = 32;

  typedef struct packed {
    logic [WT-1:0] tag;
    logic [WD-1:0] data;
    logic [N-1:0]  onehot;
  } pub_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*WT-1:0] req_tag;
  logic [N*WD-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [WT-1:0]   cdb_tag;
  logic [WD-1:0]   cdb_data;
  logic [N-1:0]    cdb_grant_onehot;

  cdb_publisher #(.N_REQ(N), .W_TAG(WT), .W_DATA(WD)) dut (
    .clk              (clk),
    .reset            (rst),
    .req_valid        (req_valid),
    .req_tag          (req_tag),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .cdb_grant_onehot (cdb_grant_onehot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  pub_t sbq[$];

  // Reference model: one pending entry per unit plus the round-robin position.
  bit            m_full [N];
  logic [WT-1:0] m_tag  [N];
  logic [WD-1:0] m_data [N];
  int            m_ptr;

  // Requester-side intent: a pending request is held until accepted.
  bit            p_v    [N];
  logic [WT-1:0] p_tag  [N];
  logic [WD-1:0] p_data [N];

  int phase;
  int cyc;
  int s0_next;
  int seen_tag5 = 0;

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic want(input int u, input logic [WT-1:0] t, input logic [WD-1:0] d);
    p_v[u] = 1'b1; p_tag[u] = t; p_data[u] = d;
  endtask

  task automatic cycle();
    int w;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!p_v[i]) begin
        case (phase)
          2: if (cyc == 0 && i == 2) want(2, 6'h2A, 32'hDEADBEEF);
          3: want(i, WT'(6'h10 + i), $urandom);
          4: if (i == 0 && s0_next <= 8) begin want(0, WT'(s0_next), $urandom); s0_next++; end
          5: begin
               if (cyc == 0 && i == 2) want(2, 6'h22, $urandom);
               if (cyc == 3 && i < 2) want(i, WT'(6'h30 + i), $urandom);
               if (cyc == 8 && i >= 2) want(i, WT'(6'h38 + i), $urandom);
             end
          6: if ($urandom_range(0, 2) == 0) want(i, WT'($urandom), $urandom);
          7: if (cyc == 0 && i == 1) want(1, 6'h05, 32'h0505_0505);
          default: ;
        endcase
      end
      req_valid[i]            = p_v[i];
      req_tag[i*WT +: WT]     = p_v[i] ? p_tag[i]  : WT'($urandom);
      req_data[i*WD +: WD]    = p_v[i] ? p_data[i] : $urandom;
    end
    w = model_winner();
    for (int i = 0; i < N; i++) exp_rdy[i] = !rst && (!m_full[i] || w == i);
    #1;
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_bad++;
      $display("FAIL ready phase=%0d cyc=%0d got=%b want=%b", phase, cyc, req_ready, exp_rdy);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_full[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
      m_ptr = 0;
      sbq.delete();
    end else begin
      if (w >= 0) begin
        sbq.push_back('{tag: m_tag[w], data: m_data[w], onehot: N'(1) << w});
        m_ptr = (w + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && exp_rdy[i]) begin
          m_full[i] = 1; m_tag[i] = p_tag[i]; m_data[i] = p_data[i]; p_v[i] = 0;
        end else if (w == i) begin
          m_full[i] = 0;
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int ph, input int n);
    phase = ph; cyc = 0;
    repeat (n) cycle();
  endtask

  // Monitor: each expected publication must appear exactly at the next sample point.
  always @(negedge clk) begin
    pub_t e;
    if (cdb_valid && cdb_tag == 6'h05 && cdb_data == 32'h0505_0505) seen_tag5++;
    if (sbq.size() > 0 || cdb_valid === 1'b1) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pub got tag=%h data=%h oh=%b want none", cdb_tag, cdb_data, cdb_grant_onehot);
      end else begin
        e = sbq.pop_front();
        if (cdb_valid !== 1'b1 || cdb_tag !== e.tag || cdb_data !== e.data || cdb_grant_onehot !== e.onehot) begin
          n_bad++;
          $display("FAIL publish got v=%b tag=%h data=%h oh=%b want v=1 tag=%h data=%h oh=%b",
                   cdb_valid, cdb_tag, cdb_data, cdb_grant_onehot, e.tag, e.data, e.onehot);
        end
      end
    end else if (!rst) begin
      n_cmp++;
      if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 || cdb_grant_onehot !== '0) begin
        n_bad++;
        $display("FAIL idle_bus got v=%b tag=%h data=%h oh=%b want all zero",
                 cdb_valid, cdb_tag, cdb_data, cdb_grant_onehot);
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_tag = '0; req_data = '0; s0_next = 1;
    for (int i = 0; i < N; i++) begin p_v[i] = 0; m_full[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
    m_ptr = 0;
    run(0, 3);
    rst = 1'b0;
    run(1, 2);
    // Pending unit-1 entry discarded by a one-cycle reset.
    run(7, 1);
    rst = 1'b1;
    for (int i = 0; i < N; i++) p_v[i] = 0;
    run(1, 1);
    rst = 1'b0;
    run(1, 3);
    run(2, 6);
    run(3, 24);
    for (int i = 0; i < N; i++) p_v[i] = 0;
    run(1, 4);
    run(4, 14);
    run(5, 16);
    run(6, 400);
    for (int i = 0; i < N; i++) p_v[i] = 0;
    run(1, 6);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain got pending=%0d want 0", sbq.size());
    end
    n_cmp++;
    if (seen_tag5 != 0) begin
      n_bad++;
      $display("FAIL reset_discard got tag05_pubs=%0d want 0", seen_tag5);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
